// File: rtl/nw_seq_aligner.sv
// Needleman-Wunsch aligner: one PE fills the DP matrix row-major (one cell per cycle), then streams the traceback.
// Latency: FILL takes len1*len2 cycles after start; the first beat follows, then one beat per accepted cycle.
// Backpressure: tb_x/tb_y/tb_last hold while tb_valid && !tb_ready; done pulses one cycle after the last accept.
module nw_seq_aligner #(
    parameter int LENGTH      = 16,
    parameter int CWIDTH      = 2,
    parameter int SWIDTH      = 16,
    parameter int WWIDTH      = 8,
    parameter int CORD_LENGTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [LENGTH*CWIDTH-1:0]   s1,
    input  logic [LENGTH*CWIDTH-1:0]   s2,
    input  logic [CORD_LENGTH-1:0]     len1,
    input  logic [CORD_LENGTH-1:0]     len2,
    input  logic signed [WWIDTH-1:0]   w_match,
    input  logic signed [WWIDTH-1:0]   w_mismatch,
    input  logic signed [WWIDTH-1:0]   w_indel,
    output logic                       busy,
    output logic signed [SWIDTH-1:0]   score,
    output logic                       score_valid,
    output logic                       tb_valid,
    input  logic                       tb_ready,
    output logic [CORD_LENGTH-1:0]     tb_x,
    output logic [CORD_LENGTH-1:0]     tb_y,
    output logic                       tb_last,
    output logic                       done
);

    localparam int IW = (LENGTH > 1) ? $clog2(LENGTH) : 1;
    localparam logic [CORD_LENGTH-1:0] ONE     = 1;
    localparam logic [CORD_LENGTH-1:0] LEN_MAX = CORD_LENGTH'(LENGTH);

    localparam logic [1:0] DIR_TOP    = 2'b00;
    localparam logic [1:0] DIR_LEFT   = 2'b01;
    localparam logic [1:0] DIR_CORNER = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FILL  = 2'd1,
        S_TRACE = 2'd2
    } state_t;

    state_t state_q, state_d;

    // Lengths of zero act as one, anything above LENGTH is cut to LENGTH.
    function automatic logic [CORD_LENGTH-1:0] clamp_len(input logic [CORD_LENGTH-1:0] l);
        if (l == '0)
            return ONE;
        else if (l > LEN_MAX)
            return LEN_MAX;
        else
            return l;
    endfunction

    function automatic logic signed [SWIDTH-1:0] sext(input logic signed [WWIDTH-1:0] w);
        return {{(SWIDTH-WWIDTH){w[WWIDTH-1]}}, w};
    endfunction

    // Job context latched at start
    logic [LENGTH*CWIDTH-1:0]  s1_q, s2_q;
    logic [CORD_LENGTH-1:0]    l1m1_q, l2m1_q;   // clamped length minus one
    logic signed [SWIDTH-1:0]  wm_q, wx_q, wi_q;

    // Fill datapath state
    logic [CORD_LENGTH-1:0]    i_q, j_q;
    logic signed [SWIDTH-1:0]  row_q [LENGTH];   // H[i-1][*] ahead of j, H[i][*] behind j
    logic signed [SWIDTH-1:0]  diag_q;           // H[i-1][j-1]
    logic signed [SWIDTH-1:0]  left_q;           // H[i][j-1]
    logic signed [SWIDTH-1:0]  rbnd_q;           // H[i-1][-1] = i*w_indel
    logic signed [SWIDTH-1:0]  cbnd_q;           // H[-1][j]   = (j+1)*w_indel
    logic [1:0]                dir_q [LENGTH][LENGTH];

    // Result / traceback state
    logic signed [SWIDTH-1:0]  score_q;
    logic                      sv_q;
    logic [CORD_LENGTH-1:0]    x_q, y_q;
    logic                      fin_q;            // last beat accepted, done is being shown

    logic [CWIDTH-1:0]         c1, c2;
    logic signed [SWIDTH-1:0]  above, left, diag, sub;
    logic signed [SWIDTH-1:0]  cand_c, cand_t, cand_l, h_new;
    logic [1:0]                dir_new;
    logic                      last_col, last_row, last_cell;
    logic                      beat_acc;

    assign c1        = s1_q[i_q[IW-1:0]*CWIDTH +: CWIDTH];
    assign c2        = s2_q[j_q[IW-1:0]*CWIDTH +: CWIDTH];
    assign last_col  = (j_q == l2m1_q);
    assign last_row  = (i_q == l1m1_q);
    assign last_cell = (state_q == S_FILL) && last_col && last_row;
    assign beat_acc  = (state_q == S_TRACE) && !fin_q && tb_ready;

    // Cell evaluation: pick the three neighbours (boundary or stored) and select the best
    always_comb begin
        above   = (i_q == '0) ? cbnd_q : row_q[j_q[IW-1:0]];
        left    = (j_q == '0) ? (rbnd_q + wi_q) : left_q;
        diag    = (j_q == '0) ? rbnd_q : diag_q;
        sub     = (c1 == c2) ? wm_q : wx_q;
        cand_c  = diag + sub;
        cand_t  = above + wi_q;
        cand_l  = left + wi_q;
        h_new   = cand_l;
        dir_new = DIR_LEFT;
        if (cand_c >= cand_t && cand_c >= cand_l) begin
            h_new   = cand_c;
            dir_new = DIR_CORNER;
        end else if (cand_t >= cand_l) begin
            h_new   = cand_t;
            dir_new = DIR_TOP;
        end
    end

    // Next-state logic for the IDLE -> FILL -> TRACE -> IDLE sequence
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start)     state_d = S_FILL;
            S_FILL:  if (last_cell) state_d = S_TRACE;
            S_TRACE: if (fin_q)     state_d = S_IDLE;
            default:                state_d = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    // Job latch, matrix fill, score capture and traceback walk
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_q    <= '0;
            s2_q    <= '0;
            l1m1_q  <= '0;
            l2m1_q  <= '0;
            wm_q    <= '0;
            wx_q    <= '0;
            wi_q    <= '0;
            i_q     <= '0;
            j_q     <= '0;
            diag_q  <= '0;
            left_q  <= '0;
            rbnd_q  <= '0;
            cbnd_q  <= '0;
            score_q <= '0;
            sv_q    <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
            fin_q   <= 1'b0;
            for (int k = 0; k < LENGTH; k++)
                row_q[k] <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        s1_q   <= s1;
                        s2_q   <= s2;
                        l1m1_q <= clamp_len(len1) - ONE;
                        l2m1_q <= clamp_len(len2) - ONE;
                        wm_q   <= sext(w_match);
                        wx_q   <= sext(w_mismatch);
                        wi_q   <= sext(w_indel);
                        i_q    <= '0;
                        j_q    <= '0;
                        rbnd_q <= '0;
                        cbnd_q <= sext(w_indel);
                        sv_q   <= 1'b0;
                    end
                end
                S_FILL: begin
                    row_q[j_q[IW-1:0]] <= h_new;
                    left_q <= h_new;
                    diag_q <= above;
                    if (last_col) begin
                        j_q    <= '0;
                        i_q    <= i_q + ONE;
                        rbnd_q <= rbnd_q + wi_q;
                        cbnd_q <= wi_q;
                    end else begin
                        j_q    <= j_q + ONE;
                        cbnd_q <= cbnd_q + wi_q;
                    end
                    if (last_row && last_col) begin
                        score_q <= h_new;
                        sv_q    <= 1'b1;
                        y_q     <= l1m1_q;
                        x_q     <= l2m1_q;
                    end
                end
                S_TRACE: begin
                    if (fin_q) begin
                        fin_q <= 1'b0;
                    end else if (beat_acc) begin
                        if (x_q == '0 && y_q == '0) begin
                            fin_q <= 1'b1;
                        end else if (y_q == '0) begin
                            x_q <= x_q - ONE;
                        end else if (x_q == '0) begin
                            y_q <= y_q - ONE;
                        end else begin
                            case (dir_q[y_q[IW-1:0]][x_q[IW-1:0]])
                                DIR_TOP:  y_q <= y_q - ONE;
                                DIR_LEFT: x_q <= x_q - ONE;
                                default: begin
                                    x_q <= x_q - ONE;
                                    y_q <= y_q - ONE;
                                end
                            endcase
                        end
                    end
                end
                default: begin
                    fin_q <= 1'b0;
                end
            endcase
        end
    end

    // Direction store: written once per cell during FILL, only read back during TRACE
    always_ff @(posedge clk) begin
        if (state_q == S_FILL)
            dir_q[i_q[IW-1:0]][j_q[IW-1:0]] <= dir_new;
    end

    assign busy        = (state_q != S_IDLE);
    assign score       = score_q;
    assign score_valid = sv_q;
    assign tb_valid    = (state_q == S_TRACE) && !fin_q;
    assign tb_x        = x_q;
    assign tb_y        = y_q;
    assign tb_last     = tb_valid && (x_q == '0) && (y_q == '0);
    assign done        = fin_q;

endmodule
